// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I sequencer: fetch/decode/execute/memory/writeback, 3-5 cycles per instruction.
// Stalls in FETCH/MEMREAD/MEMWRITE until mem_ready; outputs are forced low while rst_n is low.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        lt,
    input  logic        ltu,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        adr_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [3:0]  alu_control,
    output logic [2:0]  imm_src,
    output logic        retire,
    output logic        illegal
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_EXEC_U, S_ALUWB, S_BRANCH, S_JAL,
        S_JALR1, S_JALR2, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    state_t      state_q, state_d;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7b5;
    logic        taken;
    logic        unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign f7b5         = instr[30];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

    always_comb begin
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = ALU_ADD;
        imm_src     = 3'b000;
        retire      = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while decoding.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b010;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_LUI, OP_AUIPC:  state_d = S_EXEC_U;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR1;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (opcode == OP_STORE) begin
                    imm_src = 3'b001;
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a   = 2'b10;
                alu_control = alu_op(funct3, f7b5);
                state_d     = S_ALUWB;
            end
            S_EXEC_I: begin
                // Bit 30 is part of the immediate except for the shift-right pair.
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_op(funct3, f7b5 && (funct3 == 3'b101));
                state_d     = S_ALUWB;
            end
            S_EXEC_U: begin
                imm_src   = 3'b100;
                alu_src_b = 2'b01;
                if (opcode == OP_LUI) alu_control = ALU_PASSB;
                else                  alu_src_a   = 2'b01;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = taken;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL, S_JALR2: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_JALR1: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = S_JALR2;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset must silence the FETCH request strobe immediately, not at the next edge.
        if (!rst_n) begin
            pc_write    = 1'b0;
            ir_write    = 1'b0;
            reg_write   = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            adr_src     = 1'b0;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
            result_src  = 2'b00;
            alu_control = ALU_ADD;
            imm_src     = 3'b000;
            retire      = 1'b0;
            illegal     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: every cycle compares the full control word to a hand-built value.
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero, lt, ltu, mem_ready;
    logic        pc_write, ir_write, reg_write, mem_read, mem_write, adr_src;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [3:0]  alu_control;
    logic [2:0]  imm_src;
    logic        retire, illegal;
    logic [20:0] ctl;
    int          checks = 0;
    int          failures = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .lt(lt), .ltu(ltu),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_control(alu_control), .imm_src(imm_src),
        .retire(retire), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
                  alu_src_a, alu_src_b, result_src, alu_control, imm_src, retire, illegal};

    function automatic logic [20:0] ev(input logic pcw, irw, rw, mr, mw, as,
                                       input logic [1:0] a, b, rs,
                                       input logic [3:0] alu, input logic [2:0] imm,
                                       input logic ret, ill);
        return {pcw, irw, rw, mr, mw, as, a, b, rs, alu, imm, ret, ill};
    endfunction

    task automatic check_eq(input string tag, input logic [20:0] got, input logic [20:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Called at a falling edge: apply mem_ready, let logic settle, compare, move to next falling edge.
    task automatic cyc(input string tag, input logic mr, input logic [20:0] exp);
        mem_ready = mr;
        #1;
        check_eq(tag, ctl, exp);
        @(negedge clk);
    endtask

    logic [20:0] F_RDY, F_WAIT, DEC, WB, RST0;

    initial begin
        F_RDY  = ev(1,1,0,1,0,0, 2'b00,2'b10,2'b10, 4'h0, 3'b000, 0,0);
        F_WAIT = ev(0,0,0,1,0,0, 2'b00,2'b00,2'b00, 4'h0, 3'b000, 0,0);
        DEC    = ev(0,0,0,0,0,0, 2'b01,2'b01,2'b00, 4'h0, 3'b010, 0,0);
        WB     = ev(0,0,1,0,0,0, 2'b00,2'b00,2'b00, 4'h0, 3'b000, 1,0);
        RST0   = '0;

        rst_n = 1'b0; instr = 32'h002081B3; zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;
        #3;
        check_eq("reset_outputs", ctl, RST0);
        @(negedge clk);
        check_eq("reset_held", ctl, RST0);
        rst_n = 1'b1;

        // add x3,x1,x2
        cyc("add_fetch", 1, F_RDY);
        cyc("add_dec",   1, DEC);
        cyc("add_exec",  1, ev(0,0,0,0,0,0, 2'b10,2'b00,2'b00, 4'h0, 3'b000, 0,0));
        cyc("add_wb",    1, WB);

        // sub, preceded by one fetch wait cycle
        instr = 32'h40208233;
        cyc("sub_fwait", 0, F_WAIT);
        cyc("sub_fetch", 1, F_RDY);
        cyc("sub_dec",   1, DEC);
        cyc("sub_exec",  1, ev(0,0,0,0,0,0, 2'b10,2'b00,2'b00, 4'h1, 3'b000, 0,0));
        cyc("sub_wb",    1, WB);

        // srai
        instr = 32'h4020D213;
        cyc("srai_fetch", 1, F_RDY);
        cyc("srai_dec",   1, DEC);
        cyc("srai_exec",  1, ev(0,0,0,0,0,0, 2'b10,2'b01,2'b00, 4'h9, 3'b000, 0,0));
        cyc("srai_wb",    1, WB);

        // addi with bit 30 set stays add
        instr = 32'h40008093;
        cyc("addi_fetch", 1, F_RDY);
        cyc("addi_dec",   1, DEC);
        cyc("addi_exec",  1, ev(0,0,0,0,0,0, 2'b10,2'b01,2'b00, 4'h0, 3'b000, 0,0));
        cyc("addi_wb",    1, WB);

        // sw with 3 wait cycles; mem_ready low in DECODE/MEMADR must be ignored
        instr = 32'h0020A223;
        cyc("sw_fetch",  1, F_RDY);
        cyc("sw_dec",    0, DEC);
        cyc("sw_madr",   0, ev(0,0,0,0,0,0, 2'b10,2'b01,2'b00, 4'h0, 3'b001, 0,0));
        for (int i = 0; i < 3; i++)
            cyc("sw_wait", 0, ev(0,0,0,0,1,1, 2'b00,2'b00,2'b00, 4'h0, 3'b000, 0,0));
        cyc("sw_done",   1, ev(0,0,0,0,1,1, 2'b00,2'b00,2'b00, 4'h0, 3'b000, 1,0));

        // beq taken
        instr = 32'h00208463; zero = 1'b1;
        cyc("beq_t_fetch", 1, F_RDY);
        cyc("beq_t_dec",   1, DEC);
        cyc("beq_t_br",    1, ev(1,0,0,0,0,0, 2'b10,2'b00,2'b00, 4'h1, 3'b000, 1,0));
        // beq not taken
        zero = 1'b0;
        cyc("beq_n_fetch", 1, F_RDY);
        cyc("beq_n_dec",   1, DEC);
        cyc("beq_n_br",    1, ev(0,0,0,0,0,0, 2'b10,2'b00,2'b00, 4'h1, 3'b000, 1,0));

        // jal
        instr = 32'h008000EF;
        cyc("jal_fetch", 1, F_RDY);
        cyc("jal_dec",   1, DEC);
        cyc("jal_jump",  1, ev(1,0,0,0,0,0, 2'b01,2'b10,2'b00, 4'h0, 3'b000, 0,0));
        cyc("jal_wb",    1, WB);

        // lw abandoned by reset during the read wait
        instr = 32'h0040A183;
        cyc("lw_fetch", 1, F_RDY);
        cyc("lw_dec",   1, DEC);
        cyc("lw_madr",  1, ev(0,0,0,0,0,0, 2'b10,2'b01,2'b00, 4'h0, 3'b000, 0,0));
        cyc("lw_wait",  0, ev(0,0,0,1,0,1, 2'b00,2'b00,2'b00, 4'h0, 3'b000, 0,0));
        rst_n = 1'b0;
        #1;
        check_eq("lw_rst_now", ctl, RST0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("lw_rst_fetch", 1, F_RDY);
        cyc("lw_rst_dec",   1, DEC);

        // illegal opcode: TRAP is sticky regardless of mem_ready
        instr = 32'h0000007F;
        cyc("trap_madr", 1, ev(0,0,0,0,0,0, 2'b10,2'b01,2'b00, 4'h0, 3'b000, 0,0));
        cyc("trap_read", 1, ev(0,0,0,1,0,1, 2'b00,2'b00,2'b00, 4'h0, 3'b000, 0,0));
        cyc("trap_mwb",  1, ev(0,0,1,0,0,0, 2'b00,2'b00,2'b01, 4'h0, 3'b000, 1,0));
        cyc("trap_fetch", 1, F_RDY);
        cyc("trap_dec",   1, DEC);
        for (int i = 0; i < 10; i++)
            cyc("trap_hold", logic'(i[0]), ev(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 4'h0, 3'b000, 0,1));
        rst_n = 1'b0;
        #1;
        check_eq("trap_rst", ctl, RST0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("trap_refetch", 0, F_WAIT);
        cyc("trap_refetch_rdy", 1, F_RDY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
